// File: rtl/joystick_direction_ctrl.sv
// rtl/joystick_direction_ctrl.sv - joystick switch sync/debounce and per-step direction commit
module joystick_direction_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         CNT_W           = 18,
  parameter logic [1:0] RESET_DIR       = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       joy_up_n,
  input  logic       joy_right_n,
  input  logic       joy_down_n,
  input  logic       joy_left_n,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic       any_pressed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       raw_n;
  logic [3:0]       meta_n;
  logic [3:0]       sync_n;
  logic [3:0]       sync;
  logic [3:0]       stable;
  logic [CNT_W-1:0] cnt [4];

  logic       cand_valid;
  logic [1:0] cand;
  logic       cand_ok;
  logic [1:0] eff;
  logic       eff_valid;
  logic [1:0] pending;
  logic       pending_valid;

  assign raw_n = {joy_left_n, joy_down_n, joy_right_n, joy_up_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_n <= 4'hF;
      sync_n <= 4'hF;
    end else begin
      meta_n <= raw_n;
      sync_n <= meta_n;
    end
  end

  assign sync = ~sync_n;

  // Each counter tracks how long sync has disagreed with stable; it tops out at CNT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 4'h0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync[i] != stable[i]) begin
          if (cnt[i] == CNT_MAX) begin
            stable[i] <= sync[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_ONE;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    cand_valid = 1'b0;
    cand       = 2'b00;
    case (stable)
      4'b0001: begin cand_valid = 1'b1; cand = 2'b00; end
      4'b0010: begin cand_valid = 1'b1; cand = 2'b01; end
      4'b0100: begin cand_valid = 1'b1; cand = 2'b10; end
      4'b1000: begin cand_valid = 1'b1; cand = 2'b11; end
      default: begin cand_valid = 1'b0; cand = 2'b00; end
    endcase
  end

  // Reversal is judged against the committed dir so two presses in one step cannot U-turn.
  assign cand_ok   = cand_valid && (cand != (dir ^ 2'b10));
  assign eff       = cand_ok ? cand : pending;
  assign eff_valid = cand_ok | pending_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir           <= RESET_DIR;
      dir_changed   <= 1'b0;
      pending       <= 2'b00;
      pending_valid <= 1'b0;
      any_pressed   <= 1'b0;
    end else begin
      any_pressed <= |stable;
      if (tick && eff_valid) begin
        dir           <= eff;
        dir_changed   <= (eff != dir);
        pending_valid <= 1'b0;
      end else begin
        dir_changed <= 1'b0;
        if (cand_ok) begin
          pending       <= cand;
          pending_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_joystick_direction_ctrl.sv
// tb/tb_joystick_direction_ctrl.sv - randomized bench with behavioural model for joystick_direction_ctrl
module tb_joystick_direction_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw_n = 4'hF;
  logic       tick = 1'b0;
  logic [1:0] dir;
  logic       dir_changed;
  logic       any_pressed;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  joystick_direction_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3),
    .RESET_DIR(2'b01)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .joy_up_n(raw_n[0]),
    .joy_right_n(raw_n[1]),
    .joy_down_n(raw_n[2]),
    .joy_left_n(raw_n[3]),
    .tick(tick),
    .dir(dir),
    .dir_changed(dir_changed),
    .any_pressed(any_pressed)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: switches as bit positions {LEFT,DOWN,RIGHT,UP}, direction code = bit index,
  // a switch level is accepted once the last DEB synchronised samples all disagree with it.
  logic [3:0] m_s1 = 4'h0, m_s2 = 4'h0, m_stable = 4'h0;
  logic [3:0] m_hist [DEB];
  int m_dir = 1, m_pend = 0;
  bit m_pv = 0, m_chg = 0, m_any = 0;

  always @(posedge clk or negedge rst_n) begin
    int ones, idx, e;
    bit c_ok, alldiff;
    logic [3:0] ns;
    if (!rst_n) begin
      m_s1 = 4'h0; m_s2 = 4'h0; m_stable = 4'h0;
      for (int i = 0; i < DEB; i++) m_hist[i] = 4'h0;
      m_dir = 1; m_pend = 0; m_pv = 0; m_chg = 0; m_any = 0;
    end else begin
      ones = 0; idx = 0;
      for (int b = 0; b < 4; b++) if (m_stable[b]) begin ones++; idx = b; end
      c_ok = (ones == 1) && (idx != (m_dir + 2) % 4);
      if (tick && (c_ok || m_pv)) begin
        e = c_ok ? idx : m_pend;
        m_chg = (e != m_dir);
        m_dir = e;
        m_pv = 0;
      end else begin
        m_chg = 0;
        if (c_ok) begin m_pend = idx; m_pv = 1; end
      end
      m_any = |m_stable;
      for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_s2;
      ns = m_stable;
      for (int b = 0; b < 4; b++) begin
        alldiff = 1;
        for (int i = 0; i < DEB; i++) if (m_hist[i][b] == m_stable[b]) alldiff = 0;
        if (alldiff) ns[b] = m_hist[0][b];
      end
      m_stable = ns;
      m_s2 = m_s1;
      m_s1 = ~raw_n;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_dir", dir, m_dir);
      check("model_dir_changed", dir_changed, m_chg);
      check("model_any_pressed", any_pressed, m_any);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    int lat, hold, r, k1, k2;
    cyc(3);
    #2 rst_n = 1'b1;
    cyc(1);
    check("reset_dir", dir, 2'b01);
    check("reset_dir_changed", dir_changed, 1'b0);
    check("reset_any_pressed", any_pressed, 1'b0);

    cyc(20);
    do_tick();
    check("idle_tick_dir", dir, 2'b01);
    check("idle_tick_pulse", dir_changed, 1'b0);
    check("idle_any", any_pressed, 1'b0);

    raw_n = 4'b1110;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (any_pressed && lat == 0) lat = i;
    end
    check("press_latency", lat, 7);
    do_tick();
    check("up_dir", dir, 2'b00);
    check("up_pulse", dir_changed, 1'b1);
    cyc(1);
    check("up_pulse_one_cycle", dir_changed, 1'b0);
    raw_n = 4'hF; cyc(8);

    raw_n = 4'b1101; cyc(8); do_tick();
    check("right_dir", dir, 2'b01);
    raw_n = 4'hF; cyc(8);

    raw_n = 4'b0111; cyc(8); do_tick();
    check("reversal_dir", dir, 2'b01);
    check("reversal_pulse", dir_changed, 1'b0);
    raw_n = 4'hF; cyc(8);

    raw_n = 4'b1110; cyc(8);
    raw_n = 4'hF; cyc(8);
    raw_n = 4'b1011; cyc(8); do_tick();
    check("last_wins_dir", dir, 2'b10);
    check("last_wins_pulse", dir_changed, 1'b1);
    raw_n = 4'hF; cyc(8);
    raw_n = 4'b1101; cyc(8); do_tick();
    check("back_right", dir, 2'b01);
    raw_n = 4'hF; cyc(8);

    lat = 0;
    for (int g = 0; g < 4; g++) begin
      raw_n = 4'b1101;
      for (int i = 0; i < 2; i++) begin @(negedge clk); if (any_pressed) lat = 1; end
      raw_n = 4'hF;
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (any_pressed) lat = 1; end
    end
    cyc(6);
    check("glitch_any", lat, 0);
    do_tick();
    check("glitch_dir", dir, 2'b01);
    check("glitch_pulse", dir_changed, 1'b0);

    raw_n = 4'b0110; cyc(8);
    check("two_keys_any", any_pressed, 1'b1);
    do_tick();
    check("two_keys_dir", dir, 2'b01);
    raw_n = 4'hF; cyc(8);

    raw_n = 4'b1011; cyc(6); do_tick();
    check("same_cycle_dir", dir, 2'b10);
    check("same_cycle_pulse", dir_changed, 1'b1);
    raw_n = 4'hF; cyc(8);

    raw_n = 4'b0111; cyc(8);
    raw_n = 4'hF; cyc(8);
    raw_n = 4'b1110; cyc(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_dir", dir, 2'b01);
    check("async_reset_pulse", dir_changed, 1'b0);
    check("async_reset_any", any_pressed, 1'b0);
    raw_n = 4'hF;
    cyc(3);
    #2 rst_n = 1'b1;
    cyc(10); do_tick();
    check("pending_cleared_dir", dir, 2'b01);

    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        k1 = $urandom_range(0, 3);
        k2 = $urandom_range(0, 3);
        if (r < 3) raw_n = 4'hF;
        else if (r < 8) raw_n = ~(4'b0001 << k1);
        else if (r == 8) raw_n = ~((4'b0001 << k1) | (4'b0001 << k2));
        else raw_n = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 14);
      end else begin
        hold--;
      end
      tick = ($urandom_range(0, 4) == 0);
    end
    tick = 1'b0;
    raw_n = 4'hF;
    cyc(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
